regfile_tagged: RTL and testbench

- Parametrised successor of the core integer register file, for the out-of-order (Tomasulo/ROB) back end.
- Each architectural register carries a data value, a busy bit and the ROB tag of its pending producer.
- Decode renames the destination register. Commit writes the result back.
- Read ports return either a value or the tag to wait on, with same-cycle commit bypass.
- A flush clears all rename state on a branch mispredict.

---
 rtl/regfile_tagged_pkg.sv | 33 +++
 rtl/regfile_tagged_if.sv | 50 +++++
 rtl/regfile_rd_lookup.sv | 67 ++++++
 rtl/regfile_tagged.sv | 109 ++++++++++
 tb/tb_regfile_tagged.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_tagged_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_tagged_pkg                                           |
// | Description : Shared widths and constants for the tagged register file     |
// |               and its read lookup.                                         |
// |               Successor of the core defines header: register bus widths,   |
// |               register count, zero word, boolean constants and the ROB     |
// |               tag bus width.                                               |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package regfile_tagged_pkg;

  // Equivalents of RegBus / RegAddrBus / RegNum / RobTagBus
  localparam int unsigned c_reg_bus_w      = 32;
  localparam int unsigned c_reg_addr_bus_w = 5;
  localparam int unsigned c_reg_num        = 2 ** c_reg_addr_bus_w;
  localparam int unsigned c_rob_tag_bus_w  = 4;

  localparam logic [c_reg_bus_w-1:0] c_zero_word = '0;
  localparam logic                   c_true      = 1'b1;
  localparam logic                   c_false     = 1'b0;

  // Where a read port takes its answer from
  typedef enum logic [1:0] {
    RD_OFF    = 2'd0,  // disabled, x0, frozen or in reset
    RD_BYPASS = 2'd1,  // pending producer is committing this cycle
    RD_WAIT   = 2'd2,  // pending producer, consumer waits on the tag
    RD_VALUE  = 2'd3   // architectural value is current
  } rd_src_e;

endpackage : regfile_tagged_pkg
`default_nettype wire

// File: rtl/regfile_tagged_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_tagged_if                                            |
// | Description : Bus bundle of the tagged register file. The master side     |
// |               (decode / ROB) drives control, rename, commit and read       |
// |               requests; the slave side (register file) returns read data. |
// | Signals     : rdy, flush, rn_req/rn_addr/rn_tag, cm_req/cm_addr/cm_tag/    |
// |               cm_data, rd_req/rd_addr (in), rd_data/rd_busy/rd_tag (out)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface regfile_tagged_if
  import regfile_tagged_pkg::*;
#(
  parameter int DATA_W = c_reg_bus_w,
  parameter int ADDR_W = c_reg_addr_bus_w,
  parameter int TAG_W  = c_rob_tag_bus_w,
  parameter int NUM_RD = 2
);

  logic                     rdy;
  logic                     flush;
  logic                     rn_req;
  logic [ADDR_W-1:0]        rn_addr;
  logic [TAG_W-1:0]         rn_tag;
  logic                     cm_req;
  logic [ADDR_W-1:0]        cm_addr;
  logic [TAG_W-1:0]         cm_tag;
  logic [DATA_W-1:0]        cm_data;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;

  modport master (
    output rdy, flush, rn_req, rn_addr, rn_tag,
    output cm_req, cm_addr, cm_tag, cm_data,
    output rd_req, rd_addr,
    input  rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  rdy, flush, rn_req, rn_addr, rn_tag,
    input  cm_req, cm_addr, cm_tag, cm_data,
    input  rd_req, rd_addr,
    output rd_data, rd_busy, rd_tag
  );

endinterface : regfile_tagged_if
`default_nettype wire

// File: rtl/regfile_rd_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_rd_lookup                                            |
// | Description : One combinational read port of the tagged register file.    |
// |               Returns the committing value (bypass), the pending tag, or  |
// |               the stored value, in that priority order.                    |
// | Ports       : en        - rdy and not in reset                             |
// |               req/addr  - read request and register address                |
// |               busy_arr/tag_arr/data_arr - full register state              |
// |               cm_req/cm_tag/cm_data     - same-cycle commit for bypass     |
// |               data/busy/tag             - read result                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_rd_lookup
  import regfile_tagged_pkg::*;
#(
  parameter int DATA_W = c_reg_bus_w,
  parameter int ADDR_W = c_reg_addr_bus_w,
  parameter int TAG_W  = c_rob_tag_bus_w,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic                         en,
  input  logic                         req,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [NREG-1:0]              busy_arr,
  input  logic [NREG-1:0][TAG_W-1:0]   tag_arr,
  input  logic [NREG-1:0][DATA_W-1:0]  data_arr,
  input  logic                         cm_req,
  input  logic [TAG_W-1:0]             cm_tag,
  input  logic [DATA_W-1:0]            cm_data,
  output logic [DATA_W-1:0]            data,
  output logic                         busy,
  output logic [TAG_W-1:0]             tag
);

  rd_src_e w_src;

  always_comb begin
    w_src = RD_OFF;
    if (en && req && (addr != '0)) begin
      if (busy_arr[addr] && cm_req && (tag_arr[addr] == cm_tag)) begin
        w_src = RD_BYPASS;
      end else if (busy_arr[addr]) begin
        w_src = RD_WAIT;
      end else begin
        w_src = RD_VALUE;
      end
    end
  end

  always_comb begin
    data = '0;
    busy = c_false;
    tag  = '0;
    case (w_src)
      RD_BYPASS: data = cm_data;
      RD_WAIT: begin
        busy = c_true;
        tag  = tag_arr[addr];
      end
      RD_VALUE:  data = data_arr[addr];
      default:   data = '0;
    endcase
  end

endmodule : regfile_rd_lookup
`default_nettype wire

// File: rtl/regfile_tagged.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_tagged                                               |
// | Description : Architectural register file for an out-of-order back end.   |
// |               Each register holds data, a busy bit and the ROB tag of its  |
// |               pending producer. Decode renames, the ROB commits, a flush  |
// |               drops all rename state. Register 0 is hard-wired to zero.   |
// | Ports       : clk - clock, rising edge                                     |
// |               rst - synchronous reset, active low                          |
// |               bus - regfile_tagged_if.slave (control, rename, commit,      |
// |                     read ports)                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int DATA_W = c_reg_bus_w,
  parameter int ADDR_W = c_reg_addr_bus_w,
  parameter int TAG_W  = c_rob_tag_bus_w,
  parameter int NUM_RD = 2
) (
  input  logic             clk,
  input  logic             rst,
  regfile_tagged_if.slave  bus
);

  localparam int c_nreg = 2 ** ADDR_W;

  logic [c_nreg-1:0][DATA_W-1:0] r_data;
  logic [c_nreg-1:0]             r_busy;
  logic [c_nreg-1:0][TAG_W-1:0]  r_tag;

  logic w_rn_wr;
  logic w_cm_wr;
  logic w_cm_clr;
  logic w_rd_en;

  assign w_rn_wr = bus.rn_req && (bus.rn_addr != '0);
  assign w_cm_wr = bus.cm_req && (bus.cm_addr != '0);
  // A rename of the same register this cycle keeps it busy under the new tag
  assign w_cm_clr = w_cm_wr && (r_tag[bus.cm_addr] == bus.cm_tag) &&
                    !(w_rn_wr && (bus.rn_addr == bus.cm_addr));
  // Reads are blanked while frozen or held in reset
  assign w_rd_en = rst && bus.rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
      r_busy <= '0;
      r_tag  <= '0;
    end else if (bus.rdy) begin
      // The committing instruction is older than any flush, so its data lands
      if (w_cm_wr) begin
        r_data[bus.cm_addr] <= bus.cm_data;
      end
      if (bus.flush) begin
        r_busy <= '0;
      end else begin
        if (w_cm_clr) begin
          r_busy[bus.cm_addr] <= c_false;
        end
        if (w_rn_wr) begin
          r_busy[bus.rn_addr] <= c_true;
          r_tag[bus.rn_addr]  <= bus.rn_tag;
        end
      end
    end
  end

  logic [DATA_W-1:0] w_rd_data [NUM_RD];
  logic              w_rd_busy [NUM_RD];
  logic [TAG_W-1:0]  w_rd_tag  [NUM_RD];

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
      regfile_rd_lookup #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W)
      ) u_lookup (
        .en       (w_rd_en),
        .req      (bus.rd_req[k]),
        .addr     (bus.rd_addr[k*ADDR_W +: ADDR_W]),
        .busy_arr (r_busy),
        .tag_arr  (r_tag),
        .data_arr (r_data),
        .cm_req   (bus.cm_req),
        .cm_tag   (bus.cm_tag),
        .cm_data  (bus.cm_data),
        .data     (w_rd_data[k]),
        .busy     (w_rd_busy[k]),
        .tag      (w_rd_tag[k])
      );
    end
  endgenerate

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    bus.rd_tag  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = w_rd_data[k];
      bus.rd_busy[k]                  = w_rd_busy[k];
      bus.rd_tag[k*TAG_W +: TAG_W]    = w_rd_tag[k];
    end
  end

endmodule : regfile_tagged
`default_nettype wire

// File: tb/tb_regfile_tagged.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_tagged                                            |
// | Description : Self-checking bench for regfile_tagged: directed scenarios  |
// |               followed by random traffic against a reference model.        |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_tagged;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAG_W  = 4;
  localparam int NUM_RD = 2;
  localparam int NREG   = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_tagged_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) bus ();

  regfile_tagged #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: what each architectural register holds
  logic [DATA_W-1:0] m_data [NREG];
  bit                m_busy [NREG];
  logic [TAG_W-1:0]  m_tag  [NREG];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Architectural effect of one clock edge given the inputs currently applied
  task automatic model_edge();
    int ra, ca;
    bit same;
    ra = int'(bus.rn_addr);
    ca = int'(bus.cm_addr);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_data[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
    end else if (bus.rdy) begin
      same = bus.rn_req && bus.cm_req && (ra == ca);
      if (bus.cm_req && ca != 0) m_data[ca] = bus.cm_data;
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      end else begin
        if (bus.cm_req && ca != 0 && m_tag[ca] == bus.cm_tag && !same) m_busy[ca] = 0;
        if (bus.rn_req && ra != 0) begin
          m_busy[ra] = 1; m_tag[ra] = bus.rn_tag;
        end
      end
    end
  endtask

  task automatic model_read(input int k, output logic [DATA_W-1:0] d, output logic b, output logic [TAG_W-1:0] t);
    int a;
    a = int'(bus.rd_addr[k*ADDR_W +: ADDR_W]);
    d = '0; b = 1'b0; t = '0;
    if (rst && bus.rdy && bus.rd_req[k] && a != 0) begin
      if (m_busy[a] && bus.cm_req && m_tag[a] == bus.cm_tag) d = bus.cm_data;
      else if (m_busy[a]) begin b = 1'b1; t = m_tag[a]; end
      else d = m_data[a];
    end
  endtask

  task automatic check_model(input string pfx);
    logic [DATA_W-1:0] d;
    logic b;
    logic [TAG_W-1:0] t;
    for (int k = 0; k < NUM_RD; k++) begin
      model_read(k, d, b, t);
      check($sformatf("%s p%0d data", pfx, k), bus.rd_data[k*DATA_W +: DATA_W], d);
      check($sformatf("%s p%0d busy", pfx, k), DATA_W'(bus.rd_busy[k]), DATA_W'(b));
      check($sformatf("%s p%0d tag", pfx, k), DATA_W'(bus.rd_tag[k*TAG_W +: TAG_W]), DATA_W'(t));
    end
  endtask

  // Check the current cycle against the model, then advance one edge
  task automatic tick(input string pfx);
    #2;
    check_model(pfx);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_rd(input string name, input int k, input logic [DATA_W-1:0] d,
                           input logic b, input logic [TAG_W-1:0] t);
    check({name, " data"}, bus.rd_data[k*DATA_W +: DATA_W], d);
    check({name, " busy"}, DATA_W'(bus.rd_busy[k]), DATA_W'(b));
    check({name, " tag"}, DATA_W'(bus.rd_tag[k*TAG_W +: TAG_W]), DATA_W'(t));
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.rn_req = 1'b0; bus.rn_addr = '0; bus.rn_tag = '0;
    bus.cm_req = 1'b0; bus.cm_addr = '0; bus.cm_tag = '0; bus.cm_data = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_req = 2'b11;
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic rename(input int a, input int t);
    bus.rn_req = 1'b1; bus.rn_addr = ADDR_W'(a); bus.rn_tag = TAG_W'(t);
  endtask

  task automatic commit(input int a, input int t, input logic [DATA_W-1:0] d);
    bus.cm_req = 1'b1; bus.cm_addr = ADDR_W'(a); bus.cm_tag = TAG_W'(t); bus.cm_data = d;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_data[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
    end
    idle();
    rd(5, 5);
    rst = 1'b0;
    #1;
    tick("reset");
    tick("reset");
    #1 expect_rd("in reset", 0, '0, 1'b0, '0);
    rst = 1'b1;

    // 1: plain commit with no rename
    #1 expect_rd("x5 after reset p0", 0, '0, 1'b0, '0);
    expect_rd("x5 after reset p1", 1, '0, 1'b0, '0);
    commit(5, 3, 32'hDEADBEEF);
    tick("s1 commit");
    idle();
    #1 expect_rd("x5 committed p0", 0, 32'hDEADBEEF, 1'b0, '0);
    expect_rd("x5 committed p1", 1, 32'hDEADBEEF, 1'b0, '0);

    // 2: rename, wait on tag, bypass on commit
    rd(7, 7);
    rename(7, 2);
    #1 expect_rd("x7 no same-cycle rename", 0, '0, 1'b0, '0);
    tick("s2 rename");
    idle();
    #1 expect_rd("x7 busy", 0, '0, 1'b1, 4'd2);
    commit(7, 2, 32'h11);
    #1 expect_rd("x7 bypass", 1, 32'h11, 1'b0, '0);
    tick("s2 commit");
    idle();
    #1 expect_rd("x7 after commit", 0, 32'h11, 1'b0, '0);

    // 3: stale commit keeps the newer rename
    rename(7, 2);
    tick("s3 rn2");
    rename(7, 5);
    tick("s3 rn5");
    idle();
    commit(7, 2, 32'h22);
    #1 expect_rd("x7 stale no bypass", 0, '0, 1'b1, 4'd5);
    tick("s3 cm2");
    idle();
    #1 expect_rd("x7 still busy t5", 0, '0, 1'b1, 4'd5);
    commit(7, 5, 32'h33);
    tick("s3 cm5");
    idle();
    #1 expect_rd("x7 final", 1, 32'h33, 1'b0, '0);

    // 4: rename and commit the same register together
    rd(9, 9);
    rename(9, 1);
    tick("s4 rn1");
    idle();
    rename(9, 6);
    commit(9, 1, 32'h44);
    tick("s4 rn+cm");
    idle();
    #1 expect_rd("x9 renamed over commit", 0, '0, 1'b1, 4'd6);
    bus.flush = 1'b1;
    tick("s4 flush");
    idle();
    #1 expect_rd("x9 after flush", 0, 32'h44, 1'b0, '0);

    // 5: flush with commit and ignored rename
    commit(4, 0, 32'hAB);
    tick("s5 x4 init");
    idle();
    rename(3, 1);
    tick("s5 rn3");
    rename(4, 2);
    tick("s5 rn4");
    idle();
    bus.flush = 1'b1;
    commit(3, 1, 32'h55);
    rename(10, 7);
    tick("s5 flush");
    idle();
    rd(3, 4);
    #1 expect_rd("x3 after flush", 0, 32'h55, 1'b0, '0);
    expect_rd("x4 after flush", 1, 32'hAB, 1'b0, '0);
    rd(10, 10);
    #1 expect_rd("x10 rename dropped", 0, '0, 1'b0, '0);

    // 6: register 0 and rdy gating
    rd(0, 0);
    rename(0, 9);
    commit(0, 0, 32'hFF);
    tick("s6 x0");
    idle();
    #1 expect_rd("x0 reads zero", 1, '0, 1'b0, '0);
    rd(5, 8);
    bus.rdy = 1'b0;
    rename(8, 3);
    commit(8, 3, 32'h99);
    #1 expect_rd("rdy0 output blank", 0, '0, 1'b0, '0);
    tick("s6 frozen");
    idle();
    #1 expect_rd("x5 after freeze", 0, 32'hDEADBEEF, 1'b0, '0);
    expect_rd("x8 unchanged", 1, '0, 1'b0, '0);

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      int a;
      rst       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.rdy   = ($urandom_range(0, 9) != 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.rn_req  = $urandom_range(0, 1);
      bus.rn_addr = ADDR_W'($urandom_range(0, 7));
      bus.rn_tag  = TAG_W'($urandom);
      bus.cm_req  = $urandom_range(0, 1);
      a = $urandom_range(0, 7);
      bus.cm_addr = ADDR_W'(a);
      bus.cm_tag  = ($urandom_range(0, 3) != 0) ? m_tag[a] : TAG_W'($urandom);
      bus.cm_data = DATA_W'($urandom);
      bus.rd_req  = NUM_RD'($urandom);
      for (int k = 0; k < NUM_RD; k++)
        bus.rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      tick("rand");
    end

    // Reset in the middle of activity
    rst = 1'b1;
    idle();
    rename(6, 4);
    tick("pre-reset");
    idle();
    rst = 1'b0;
    tick("mid reset");
    rst = 1'b1;
    rd(5, 6);
    #1 expect_rd("x5 after reset", 0, '0, 1'b0, '0);
    expect_rd("x6 after reset", 1, '0, 1'b0, '0);
    tick("post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_regfile_tagged
`default_nettype wire
